// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS-subset core.
// FSM-sequenced datapath with one register file, one shared ALU and
// registered IR/A/B/ALUOUT/MDR. Instruction and data ports use a req/ready
// handshake so wait-state memories are tolerated.
// Optional feature: define MCORE_JUMP_EN to enable the j instruction
// (opcode 000010); otherwise that opcode is illegal and halts the core.
module mips_multicycle_core #(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic            retire,
  output logic            halted
);

  localparam int RIDX = $clog2(NREG);

`ifdef MCORE_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  state_t          r_state, w_state_n;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_aluout, r_mdr;
  logic [31:0]     r_ir;
  logic            r_run;  // low for one cycle after reset so requests drop at the reset edge
  logic [XLEN-1:0] r_rf [NREG];

  logic [5:0]      w_opcode, w_funct;
  logic [RIDX-1:0] w_rs, w_rt, w_rd, w_wb_idx;
  logic            w_is_r, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_halt, w_is_j, w_legal;
  alu_op_t         w_alu_op;
  logic [XLEN-1:0] w_alu_b, w_alu_y, w_wb_data;
  logic            w_alu_zero, w_misaligned, w_fetch_done;

  assign w_opcode     = r_ir[31:26];
  assign w_funct      = r_ir[5:0];
  assign w_rs         = r_ir[21 +: RIDX];
  assign w_rt         = r_ir[16 +: RIDX];
  assign w_rd         = r_ir[11 +: RIDX];
  assign w_wb_idx     = w_is_r ? w_rd : w_rt;
  assign w_wb_data    = w_is_lw ? r_mdr : r_aluout;
  assign w_alu_zero   = (w_alu_y == '0);
  assign w_misaligned = (w_alu_y[1:0] != 2'b00);
  assign w_fetch_done = r_run && imem_ready;

  assign imem_addr  = r_pc;
  assign pc_out     = r_pc;
  assign dmem_addr  = r_aluout;
  assign dmem_wdata = r_b;

  // Instruction classification from the held IR.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_is_r    = (w_opcode == OP_RTYPE);
    w_is_addi = (w_opcode == OP_ADDI);
    w_is_lw   = (w_opcode == OP_LW);
    w_is_sw   = (w_opcode == OP_SW);
    w_is_beq  = (w_opcode == OP_BEQ);
    w_is_halt = (w_opcode == OP_HALT);
    w_is_j    = JUMP_EN && (w_opcode == OP_J);
    w_legal   = w_is_addi || w_is_lw || w_is_sw || w_is_beq || w_is_halt || w_is_j;
    w_alu_op  = ALU_ADD;
    if (w_is_r) begin
      w_legal = 1'b1;
      case (w_funct)
        F_ADD:   w_alu_op = ALU_ADD;
        F_SUB:   w_alu_op = ALU_SUB;
        F_AND:   w_alu_op = ALU_AND;
        F_OR:    w_alu_op = ALU_OR;
        F_SLT:   w_alu_op = ALU_SLT;
        default: w_legal  = 1'b0;
      endcase
    end else if (w_is_beq) begin
      w_alu_op = ALU_SUB;
    end
  end

  // Shared ALU: register operand for R-type/beq, sign-extended immediate otherwise.
  always_comb begin
    w_alu_b = (w_is_r || w_is_beq) ? r_b : r_imm;
    case (w_alu_op)
      ALU_ADD: w_alu_y = r_a + w_alu_b;
      ALU_SUB: w_alu_y = r_a - w_alu_b;
      ALU_AND: w_alu_y = r_a & w_alu_b;
      ALU_OR:  w_alu_y = r_a | w_alu_b;
      ALU_SLT: w_alu_y = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_y = r_a + w_alu_b;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_n;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    w_state_n = r_state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = r_run;
        if (w_fetch_done) w_state_n = S_DECODE;
      end
      S_DECODE: begin
        if (!w_legal || w_is_halt) w_state_n = S_HALT;
        else if (w_is_j) begin
          retire    = 1'b1;
          w_state_n = S_FETCH;
        end else w_state_n = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_beq) begin
          retire    = 1'b1;
          w_state_n = S_FETCH;
        end else if (w_is_lw || w_is_sw) w_state_n = w_misaligned ? S_HALT : S_MEM;
        else w_state_n = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_sw;
        if (dmem_ready) begin
          retire    = w_is_sw;
          w_state_n = w_is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        retire    = 1'b1;
        w_state_n = S_FETCH;
      end
      S_HALT:  halted    = 1'b1;
      default: w_state_n = S_HALT;
    endcase
  end

  // Datapath registers, PC and register file, sequenced by the current state.
  // NOTE: the register file is reset in full because architectural state must start at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= PC_RESET;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_run    <= 1'b0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_FETCH: if (w_fetch_done) begin
          r_ir <= imem_rdata;
          r_pc <= r_pc + XLEN'(4);
        end
        S_DECODE: begin
          r_a   <= r_rf[w_rs];
          r_b   <= r_rf[w_rt];
          r_imm <= {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
          if (w_is_j) r_pc <= {r_pc[XLEN-1:28], r_ir[25:0], 2'b00};
        end
        S_EXEC: begin
          r_aluout <= w_alu_y;
          if (w_is_beq && w_alu_zero) r_pc <= r_pc + (r_imm << 2);
        end
        S_MEM: if (dmem_ready && w_is_lw) r_mdr <= dmem_rdata;
        S_WB: if (w_wb_idx != '0) r_rf[w_wb_idx] <= w_wb_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: memory responders with
// programmable wait states, a scoreboard of expected retirements and data
// accesses, and a monitor that pops and compares as the core presents them.
module tb_mips_multicycle_core;

  localparam logic [31:0] PCR    = 32'h80;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        clk, rst;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;

  mips_multicycle_core #(.XLEN(32), .NREG(32), .PC_RESET(PCR)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc_out(pc_out), .retire(retire), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard entries.
  typedef struct { logic [31:0] pc; int lat; } ret_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; int cycles; } dm_t;
  ret_t ret_q[$];
  dm_t  dm_q[$];

  task automatic exp_ret(input logic [31:0] pc, input int lat);
    ret_t e;
    e.pc = pc; e.lat = lat;
    ret_q.push_back(e);
  endtask

  task automatic exp_dm(input logic we, input logic [31:0] addr, input logic [31:0] data, input int cyc);
    dm_t e;
    e.we = we; e.addr = addr; e.data = data; e.cycles = cyc;
    dm_q.push_back(e);
  endtask

  // Instruction encoders.
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] f);
    return {6'b000000, rs[4:0], rt[4:0], rd[4:0], 5'b00000, f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  // Memories and wait-state responders (driven just after each rising edge).
  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;

  initial begin
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_req) begin
        if (icnt >= iwait) begin
          imem_ready = 1'b1;
          imem_rdata = imem[imem_addr[9:2]];
        end else begin
          imem_ready = 1'b0;
          icnt++;
        end
      end else begin
        imem_ready = 1'b0;
        icnt = 0;
      end
      if (dmem_req) begin
        if (dcnt >= dwait) begin
          dmem_ready = 1'b1;
          if (dmem_we) dmem[dmem_addr[7:2]] = dmem_wdata;
          else         dmem_rdata = dmem[dmem_addr[7:2]];
        end else begin
          dmem_ready = 1'b0;
          dcnt++;
        end
      end else begin
        dmem_ready = 1'b0;
        dcnt = 0;
      end
    end
  end

  // Monitor: pops and compares whenever the core retires or completes a data access.
  int          cyc = 0, start = 0, dreq_cycles = 0;
  logic        prev_ret = 1'b0, prev_ireq = 1'b0;
  logic [31:0] exp_pc = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_ret = 1'b0; prev_ireq = 1'b0; dreq_cycles = 0;
      end else begin
        if (prev_ret) check("retire_pc", pc_out, exp_pc);
        if (imem_req && !prev_ireq) start = cyc;
        if (retire) check("retire_and_halted", halted, 1'b0);
        if (retire) begin
          check("retire_expected", ret_q.size() > 0, 1'b1);
          if (ret_q.size() > 0) begin
            ret_t e;
            e = ret_q.pop_front();
            check("retire_latency", cyc - start + 1, e.lat);
            exp_pc = e.pc;
          end
        end
        if (dmem_req) dreq_cycles++;
        if (dmem_req && dmem_ready) begin
          check("dmem_expected", dm_q.size() > 0, 1'b1);
          if (dm_q.size() > 0) begin
            dm_t d;
            d = dm_q.pop_front();
            check("dmem_we", dmem_we, d.we);
            check("dmem_addr", dmem_addr, d.addr);
            if (d.we) check("dmem_wdata", dmem_wdata, d.data);
            check("dmem_req_cycles", dreq_cycles, d.cycles);
          end
          dreq_cycles = 0;
        end
        prev_ireq = imem_req;
        prev_ret  = retire;
      end
    end
  end

  task automatic fill_imem();
    for (int i = 0; i < 256; i++) imem[i] = HALT_W;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_retire", retire, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_pc", pc_out, PCR);
    check("rst_imem_addr", imem_addr, PCR);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((ret_q.size() != 0 || dm_q.size() != 0 || prev_ret) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, ret_q.size() + dm_q.size(), 0);
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, halted, 1'b1);
  endtask

  initial begin
    int busy;
    rst = 1'b1;

    // A: ALU ops, stores/loads with 3 data wait states, R0, beq not-taken then loop.
    fill_imem();
    imem[32] = enc_i(6'b001000, 0, 1, 5);        // addi r1,r0,5
    imem[33] = enc_i(6'b001000, 0, 2, -3);       // addi r2,r0,-3
    imem[34] = enc_r(1, 2, 3, 6'b100000);        // add r3,r1,r2
    imem[35] = enc_i(6'b101011, 0, 3, 4);        // sw r3,4(r0)
    imem[36] = enc_i(6'b101011, 0, 1, 8);        // sw r1,8(r0)
    imem[37] = enc_i(6'b100011, 0, 4, 8);        // lw r4,8(r0)
    imem[38] = enc_i(6'b101011, 0, 4, 12);       // sw r4,12(r0)
    imem[39] = enc_r(2, 1, 5, 6'b101010);        // slt r5,r2,r1
    imem[40] = enc_r(2, 1, 6, 6'b100010);        // sub r6,r2,r1
    imem[41] = enc_r(1, 2, 7, 6'b100100);        // and r7,r1,r2
    imem[42] = enc_r(1, 2, 8, 6'b100101);        // or  r8,r1,r2
    imem[43] = enc_r(1, 2, 9, 6'b101010);        // slt r9,r1,r2
    imem[44] = enc_r(1, 1, 0, 6'b100000);        // add r0,r1,r1
    imem[45] = enc_i(6'b101011, 0, 5, 16);       // sw r5,16
    imem[46] = enc_i(6'b101011, 0, 6, 20);       // sw r6,20
    imem[47] = enc_i(6'b101011, 0, 7, 24);       // sw r7,24
    imem[48] = enc_i(6'b101011, 0, 8, 28);       // sw r8,28
    imem[49] = enc_i(6'b101011, 0, 9, 32);       // sw r9,32
    imem[50] = enc_i(6'b101011, 0, 0, 36);       // sw r0,36
    imem[51] = enc_i(6'b000100, 1, 2, 5);        // beq r1,r2,+5 (not taken)
    imem[52] = enc_i(6'b000100, 5, 5, -1);       // beq r5,r5,-1 (self loop)
    iwait = 0; dwait = 3;
    exp_ret(32'h84, 4); exp_ret(32'h88, 4); exp_ret(32'h8C, 4);
    exp_ret(32'h90, 7); exp_dm(1'b1, 32'd4, 32'd2, 4);
    exp_ret(32'h94, 7); exp_dm(1'b1, 32'd8, 32'd5, 4);
    exp_ret(32'h98, 8); exp_dm(1'b0, 32'd8, 32'd0, 4);
    exp_ret(32'h9C, 7); exp_dm(1'b1, 32'd12, 32'd5, 4);
    exp_ret(32'hA0, 4); exp_ret(32'hA4, 4); exp_ret(32'hA8, 4);
    exp_ret(32'hAC, 4); exp_ret(32'hB0, 4); exp_ret(32'hB4, 4);
    exp_ret(32'hB8, 7); exp_dm(1'b1, 32'd16, 32'd1, 4);
    exp_ret(32'hBC, 7); exp_dm(1'b1, 32'd20, 32'hFFFF_FFF8, 4);
    exp_ret(32'hC0, 7); exp_dm(1'b1, 32'd24, 32'd5, 4);
    exp_ret(32'hC4, 7); exp_dm(1'b1, 32'd28, 32'hFFFF_FFFD, 4);
    exp_ret(32'hC8, 7); exp_dm(1'b1, 32'd32, 32'd0, 4);
    exp_ret(32'hCC, 7); exp_dm(1'b1, 32'd36, 32'd0, 4);
    exp_ret(32'hD0, 3);
    exp_ret(32'hD0, 3); exp_ret(32'hD0, 3); exp_ret(32'hD0, 3);
    do_reset();
    wait_drain("A_drain", 600);
    check("A_not_halted", halted, 1'b0);

    // B: misaligned load halts with no data request and no retire.
    fill_imem();
    imem[32] = enc_i(6'b100011, 0, 6, 2);        // lw r6,2(r0)
    iwait = 0; dwait = 0;
    do_reset();
    wait_halt("B_halted", 50);
    check("B_pc", pc_out, 32'h84);
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req || dmem_req) busy++;
    end
    check("B_no_req_after_halt", busy, 0);
    check("B_halted_sticky", halted, 1'b1);

    // C: reset during an instruction-fetch wait abandons the fetch.
    fill_imem();
    imem[32] = enc_i(6'b001000, 0, 1, 7);        // addi r1,r0,7
    imem[33] = enc_i(6'b101011, 0, 1, 0);        // sw r1,0(r0)
    iwait = 5; dwait = 0;
    do_reset();
    busy = 0;
    while (!imem_req && busy < 20) begin
      @(negedge clk);
      busy++;
    end
    check("C_fetch_started", imem_req, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("C_req_dropped", imem_req, 1'b0);
    check("C_pc_reset", pc_out, PCR);
    exp_ret(32'h84, 9);
    exp_ret(32'h88, 9); exp_dm(1'b1, 32'd0, 32'd7, 1);
    rst = 1'b0;
    wait_halt("C_halted", 200);
    check("C_pc", pc_out, 32'h8C);
    wait_drain("C_drain", 20);

    // D: opcode 000010 with target 0x40.
    fill_imem();
    imem[32] = {6'b000010, 26'h40};
    iwait = 0; dwait = 0;
`ifdef MCORE_JUMP_EN
    exp_ret(32'h100, 2);
`endif
    do_reset();
    wait_halt("D_halted", 100);
`ifdef MCORE_JUMP_EN
    check("D_pc", pc_out, 32'h104);
`else
    check("D_pc", pc_out, 32'h84);
`endif
    wait_drain("D_drain", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
